ap_ctrl_hs_driver: RTL and testbench
====================================

AP_CTRL_HS_DRIVER -- requirements
Module: ap_ctrl_hs_driver

Interface
REQ-001 SHALL have parameter NUM_W, default 16, width of transaction counts.
REQ-002 SHALL have parameter CNT_W, default 32, width of cycle/latency counters.
REQ-003 SHALL have parameter DEPTH, default 4, max outstanding transactions (power of 2).
REQ-004 SHALL have port clock  in  1  sole clock, all logic on posedge.
REQ-005 SHALL have port reset  in  1  asynchronous, active-high reset.
REQ-006 SHALL have port cfg_start  in  1  pulse, begin a run.
REQ-007 SHALL have port cfg_num  in  NUM_W  transactions to issue in the run.
REQ-008 SHALL have port cfg_gap  in  8  idle cycles inserted after each accepted start.
REQ-009 SHALL have port ap_start  out  1  start request to child block.
REQ-010 SHALL have port ap_ready  in  1  child accepted start.
REQ-011 SHALL have port ap_done  in  1  child completed one transaction (1-cycle pulse).
REQ-012 SHALL have port busy  out  1  run in progress.
REQ-013 SHALL have port run_done  out  1  1-cycle pulse at run end.
REQ-014 SHALL have ports issued, completed  out  NUM_W each  accepted starts / received dones this run.
REQ-015 SHALL have ports last_lat, max_lat  out  CNT_W each  latency of most recent / worst transaction.
REQ-016 SHALL have port total_cycles  out  CNT_W  cycles from run start to run_done.
REQ-017 SHALL have port err_spurious  out  1  sticky, ap_done seen with nothing outstanding.

Function
REQ-018 SHALL implement states IDLE, ISSUE, GAP, DRAIN, FINISH.
REQ-019 IDLE: cfg_start=1 latches cfg_num/cfg_gap, clears issued/completed/last_lat/max_lat/total_cycles/err_spurious, goes to ISSUE (FINISH if cfg_num=0); cfg_start ignored outside IDLE.
REQ-020 ISSUE: ap_start=1 whenever outstanding<DEPTH; ap_start=0 while outstanding==DEPTH.
REQ-021 Accept = ap_start&ap_ready in same cycle; ap_start SHALL stay high until accept (no withdrawal).
REQ-022 On accept: issued+1, push free-running cycle count to timestamp FIFO; if issued+1==cfg_num go DRAIN, else if cfg_gap>0 go GAP, else stay ISSUE (back-to-back, ap_start stays high).
REQ-023 GAP: ap_start=0 for exactly cfg_gap cycles, then ISSUE.
REQ-024 DRAIN: ap_start=0; when outstanding reaches 0 go FINISH.
REQ-025 FINISH: run_done=1 for one cycle, total_cycles frozen, then IDLE.
REQ-026 busy=1 in ISSUE, GAP, DRAIN, FINISH; 0 in IDLE.
REQ-027 Cycle counter SHALL start at 0 on run start, increment each cycle while busy, saturate at all-ones.
REQ-028 On ap_done with FIFO non-empty: pop head, last_lat = counter - head timestamp, max_lat = max(max_lat,last_lat), completed+1.
REQ-029 Latency SHALL be measured from accept cycle to done cycle inclusive-exclusive (done 1 cycle after accept gives 1).
REQ-030 ap_done with FIFO empty (and no same-cycle accept): set err_spurious, no counter change.
REQ-031 Simultaneous accept and done: push and pop same cycle, occupancy unchanged; if FIFO was empty the pushed entry is popped with latency 0.
REQ-032 ap_done in IDLE SHALL only set err_spurious.
REQ-033 total_cycles SHALL equal counter value in the FINISH cycle.

Reset
REQ-034 reset=1 SHALL immediately force IDLE, FIFO empty, ap_start=0, busy=0, run_done=0, all counters/latencies 0, err_spurious=0.
REQ-035 Reset mid-run SHALL abandon outstanding transactions; subsequent dones after release set err_spurious.

Verification
REQ-036 cfg_num=3, gap=0, child ready same cycle, done 5 cycles after accept -> ap_start high 3 consecutive cycles, last_lat=max_lat=5, completed=3, one run_done.
REQ-037 cfg_num=6, DEPTH=4, child never sends done until 4 accepted -> ap_start drops after 4th accept, resumes one cycle after first done.
REQ-038 cfg_num=2, gap=3 -> exactly 3 ap_start-low cycles between accepts.
REQ-039 cfg_num=0 -> busy 1 cycle (FINISH), run_done pulse, issued=0, total_cycles=0.
REQ-040 ap_done pulse in IDLE -> err_spurious=1, completed=0; reset mid-run (issued=2) -> all outputs 0 next cycle.
REQ-041 latencies 4,9,2 -> last_lat=2, max_lat=9; cfg_start during busy ignored.

Source files
------------

// File: rtl/ap_ctrl_hs_driver.sv
// Drives an ap_ctrl_hs child block through a run of cfg_num transactions,
// keeping up to DEPTH in flight and measuring per-transaction latency.
module ap_ctrl_hs_driver #(
  parameter int NUM_W = 16,
  parameter int CNT_W = 32,
  parameter int DEPTH = 4
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             cfg_start,
  input  logic [NUM_W-1:0] cfg_num,
  input  logic [7:0]       cfg_gap,
  output logic             ap_start,
  input  logic             ap_ready,
  input  logic             ap_done,
  output logic             busy,
  output logic             run_done,
  output logic [NUM_W-1:0] issued,
  output logic [NUM_W-1:0] completed,
  output logic [CNT_W-1:0] last_lat,
  output logic [CNT_W-1:0] max_lat,
  output logic [CNT_W-1:0] total_cycles,
  output logic             err_spurious,
  output logic [2:0]       dbg_state
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [AW:0] FULL = (AW+1)'(DEPTH);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_ISSUE  = 3'd1,
    S_GAP    = 3'd2,
    S_DRAIN  = 3'd3,
    S_FINISH = 3'd4
  } state_t;

  state_t           state, state_nx;
  logic [NUM_W-1:0] num_q;
  logic [7:0]       gap_q, gap_cnt;
  logic [CNT_W-1:0] cyc_cnt;
  logic [CNT_W-1:0] ts_mem [DEPTH];
  logic [AW-1:0]    wr_ptr, rd_ptr;
  logic [AW:0]      occ;
  logic             start_run, accept, fifo_empty, pop, spurious;
  logic [CNT_W-1:0] head_ts, lat;

  // Handshake: a transfer happens in any cycle where ap_start and ap_ready are
  // both high; ap_start depends only on registered state, so once raised it
  // holds until that transfer (it can never drop while the child is stalling).
  assign ap_start   = (state == S_ISSUE) && (occ < FULL);
  assign accept     = ap_start & ap_ready;
  assign fifo_empty = (occ == '0);
  assign start_run  = (state == S_IDLE) && cfg_start;
  assign pop        = ap_done & (!fifo_empty | accept);
  assign spurious   = ap_done & fifo_empty & !accept;
  // A done landing with an empty FIFO pairs with the same-cycle accept.
  assign head_ts    = fifo_empty ? cyc_cnt : ts_mem[rd_ptr];
  assign lat        = cyc_cnt - head_ts;

  assign busy      = (state != S_IDLE);
  assign run_done  = (state == S_FINISH);
  assign dbg_state = state;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) state <= S_IDLE;
    else       state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    unique case (state)
      S_IDLE:   if (cfg_start) state_nx = (cfg_num == '0) ? S_FINISH : S_ISSUE;
      S_ISSUE: begin
        if (accept) begin
          if (issued + NUM_W'(1) == num_q) state_nx = S_DRAIN;
          else if (gap_q != 8'd0)          state_nx = S_GAP;
        end
      end
      S_GAP:    if (gap_cnt == 8'd1) state_nx = S_ISSUE;
      S_DRAIN:  if (fifo_empty) state_nx = S_FINISH;
      S_FINISH: state_nx = S_IDLE;
      default:  state_nx = S_IDLE;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      num_q        <= '0;
      gap_q        <= '0;
      gap_cnt      <= '0;
      cyc_cnt      <= '0;
      wr_ptr       <= '0;
      rd_ptr       <= '0;
      occ          <= '0;
      issued       <= '0;
      completed    <= '0;
      last_lat     <= '0;
      max_lat      <= '0;
      total_cycles <= '0;
      err_spurious <= 1'b0;
    end else if (start_run) begin
      num_q        <= cfg_num;
      gap_q        <= cfg_gap;
      cyc_cnt      <= '0;
      issued       <= '0;
      completed    <= '0;
      last_lat     <= '0;
      max_lat      <= '0;
      total_cycles <= '0;
      err_spurious <= 1'b0;
    end else begin
      if (busy && (cyc_cnt != '1)) cyc_cnt <= cyc_cnt + CNT_W'(1);
      if (accept) begin
        issued <= issued + NUM_W'(1);
        wr_ptr <= wr_ptr + AW'(1);
      end
      if (pop) begin
        rd_ptr    <= rd_ptr + AW'(1);
        last_lat  <= lat;
        completed <= completed + NUM_W'(1);
        if (lat > max_lat) max_lat <= lat;
      end
      if (accept && !pop)      occ <= occ + (AW+1)'(1);
      else if (!accept && pop) occ <= occ - (AW+1)'(1);
      if (spurious) err_spurious <= 1'b1;
      if (state == S_FINISH) total_cycles <= cyc_cnt;
      if (accept)                gap_cnt <= gap_q;
      else if (state == S_GAP)   gap_cnt <= gap_cnt - 8'd1;
    end
  end

  // Timestamp storage needs no reset: occupancy alone says what is valid.
  always_ff @(posedge clock) begin
    if (accept) ts_mem[wr_ptr] <= cyc_cnt;
  end

endmodule

// File: tb/tb_ap_ctrl_hs_driver.sv
// Bench for ap_ctrl_hs_driver: emulated child with configurable latency and a
// transaction-level reference model compared against the DUT every cycle.
module tb_ap_ctrl_hs_driver;

  localparam int NUM_W = 16;
  localparam int CNT_W = 32;
  localparam int DEPTH = 4;

  // ---------------- clock / reset ----------------
  logic clock = 1'b0;
  logic reset;
  always #5 clock = ~clock;

  logic             cfg_start, ap_start, ap_ready, ap_done;
  logic [NUM_W-1:0] cfg_num, issued, completed;
  logic [7:0]       cfg_gap;
  logic             busy, run_done, err_spurious;
  logic [CNT_W-1:0] last_lat, max_lat, total_cycles;
  logic [2:0]       dbg_state;

  ap_ctrl_hs_driver #(.NUM_W(NUM_W), .CNT_W(CNT_W), .DEPTH(DEPTH)) dut (
    .clock(clock), .reset(reset), .cfg_start(cfg_start), .cfg_num(cfg_num),
    .cfg_gap(cfg_gap), .ap_start(ap_start), .ap_ready(ap_ready), .ap_done(ap_done),
    .busy(busy), .run_done(run_done), .issued(issued), .completed(completed),
    .last_lat(last_lat), .max_lat(max_lat), .total_cycles(total_cycles),
    .err_spurious(err_spurious), .dbg_state(dbg_state)
  );

  // ---------------- scoreboard ----------------
  int checks = 0;
  int failures = 0;

  task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0d exp=%0d (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Reference model: a run is a count of starts still owed, a gap countdown,
  // and a queue of accept timestamps that dones retire in order.
  bit m_active, m_final, m_err;
  int m_num, m_gap, m_gap_left, m_issued, m_completed, m_last, m_max, m_total, m_cycle;
  int ts_q[$];

  // Emulated child: due cycles of pending dones, delivered in order.
  int tb_cyc = 0;
  int due_q[$];
  int lat_mode = 0;
  int lat_fixed = 5;
  int lat_list[$];

  // Observations of the DUT for directed checks.
  int acc_q[$];
  int done_cyc_q[$];
  int start_hi_cnt, run_done_cnt, busy_cnt;

  function automatic bit model_start();
    return m_active && !m_final && (m_issued < m_num) && (m_gap_left == 0) &&
           (ts_q.size() < DEPTH);
  endfunction

  function automatic int next_lat();
    if (lat_mode == 2) return $urandom_range(1, 12);
    if (lat_mode == 1 && lat_list.size() > 0) return lat_list.pop_front();
    return lat_fixed;
  endfunction

  task automatic model_clear();
    m_active = 0; m_final = 0; m_err = 0;
    m_num = 0; m_gap = 0; m_gap_left = 0; m_issued = 0; m_completed = 0;
    m_last = 0; m_max = 0; m_total = 0; m_cycle = 0;
    ts_q.delete();
  endtask

  task automatic model_step(input bit start, input int num, input int gap, input bit acc, input bit dn);
    bit drained;
    if (!m_active) begin
      if (start) begin
        m_active = 1; m_final = (num == 0);
        m_num = num; m_gap = gap; m_gap_left = 0;
        m_issued = 0; m_completed = 0; m_last = 0; m_max = 0; m_total = 0;
        m_err = 0; m_cycle = 0;
      end else if (dn) begin
        m_err = 1;
      end
    end else if (m_final) begin
      m_total = m_cycle;
      if (dn) m_err = 1;
      m_active = 0; m_final = 0;
    end else begin
      drained = (m_issued == m_num) && (ts_q.size() == 0);
      if (acc) begin
        ts_q.push_back(m_cycle);
        m_issued++;
        if (m_issued < m_num && m_gap > 0) m_gap_left = m_gap;
      end else if (m_gap_left > 0) begin
        m_gap_left--;
      end
      if (dn) begin
        if (ts_q.size() > 0) begin
          m_last = m_cycle - ts_q.pop_front();
          if (m_last > m_max) m_max = m_last;
          m_completed++;
        end else begin
          m_err = 1;
        end
      end
      m_cycle++;
      if (drained) m_final = 1;
    end
  endtask

  // ---------------- driver tasks ----------------
  // Called just after a rising edge; drives one cycle, checks at the falling edge.
  task automatic cycle(input bit start, input int num, input int gap, input bit ready, input bit extra_done);
    bit exp_start, acc, dn;
    dn = extra_done;
    if (due_q.size() > 0 && due_q[0] <= tb_cyc) begin
      void'(due_q.pop_front());
      dn = 1;
    end
    cfg_start = start;
    cfg_num   = num[NUM_W-1:0];
    cfg_gap   = gap[7:0];
    ap_ready  = ready;
    ap_done   = dn;
    exp_start = model_start();
    @(negedge clock);
    check_val("ap_start", ap_start, exp_start);
    check_val("busy", busy, m_active);
    check_val("run_done", run_done, m_final);
    check_val("issued", issued, m_issued);
    check_val("completed", completed, m_completed);
    check_val("last_lat", last_lat, m_last);
    check_val("max_lat", max_lat, m_max);
    check_val("total_cycles", total_cycles, m_total);
    check_val("err_spurious", err_spurious, m_err);
    if (ap_start) start_hi_cnt++;
    if (ap_start && ready) acc_q.push_back(tb_cyc);
    if (run_done) run_done_cnt++;
    if (busy) busy_cnt++;
    if (dn) done_cyc_q.push_back(tb_cyc);
    acc = exp_start && ready;
    if (acc) due_q.push_back(tb_cyc + next_lat());
    model_step(start, num, gap, acc, dn);
    @(posedge clock);
    #1;
    tb_cyc++;
  endtask

  task automatic clear_obs();
    acc_q.delete(); done_cyc_q.delete();
    start_hi_cnt = 0; run_done_cnt = 0; busy_cnt = 0;
  endtask

  task automatic wait_idle(input int ready_pct);
    for (int i = 0; i < 2000 && m_active; i++)
      cycle(0, 0, 0, ($urandom_range(1, 100) <= ready_pct), 0);
    check_val("run_timeout", busy, 0);
  endtask

  task automatic run(input int num, input int gap, input int ready_pct);
    clear_obs();
    cycle(1, num, gap, 0, 0);
    wait_idle(ready_pct);
  endtask

  task automatic pulse_reset();
    cfg_start = 0; ap_ready = 0; ap_done = 0;
    reset = 1;
    #1;
    check_val("rst_ap_start", ap_start, 0);
    check_val("rst_busy", busy, 0);
    check_val("rst_run_done", run_done, 0);
    check_val("rst_issued", issued, 0);
    check_val("rst_completed", completed, 0);
    check_val("rst_last_lat", last_lat, 0);
    check_val("rst_max_lat", max_lat, 0);
    check_val("rst_total", total_cycles, 0);
    check_val("rst_err", err_spurious, 0);
    model_clear();
    @(posedge clock);
    #1;
    reset = 0;
    tb_cyc++;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog expired got=running exp=finished");
    failures++;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $fatal(1, "watchdog");
  end

  // ---------------- stimulus ----------------
  initial begin
    cfg_start = 0; cfg_num = '0; cfg_gap = '0; ap_ready = 0; ap_done = 0;
    model_clear();
    @(posedge clock);
    pulse_reset();

    // Back-to-back, fixed latency 5.
    lat_mode = 0; lat_fixed = 5;
    run(3, 0, 100);
    check_val("bb_start_hi", start_hi_cnt, 3);
    check_val("bb_consecutive", acc_q[2] - acc_q[0], 2);
    check_val("bb_last_lat", last_lat, 5);
    check_val("bb_max_lat", max_lat, 5);
    check_val("bb_completed", completed, 3);
    check_val("bb_run_done", run_done_cnt, 1);

    // Full window of DEPTH outstanding.
    lat_fixed = 10;
    run(6, 0, 100);
    check_val("full_first4", acc_q[3] - acc_q[0], 3);
    check_val("full_resume", acc_q[4] - done_cyc_q[0], 1);
    check_val("full_issued", issued, 6);

    // Gap of 3 idle cycles.
    lat_fixed = 2;
    run(2, 3, 100);
    check_val("gap_spacing", acc_q[1] - acc_q[0], 4);

    // Zero-length run.
    run(0, 0, 100);
    check_val("zero_busy", busy_cnt, 1);
    check_val("zero_run_done", run_done_cnt, 1);
    check_val("zero_issued", issued, 0);
    check_val("zero_total", total_cycles, 0);

    // Spurious done in idle.
    cycle(0, 0, 0, 0, 1);
    check_val("idle_err", err_spurious, 1);
    check_val("idle_completed", completed, 0);

    // Reset mid-run after two accepts; leftover dones must flag spurious.
    lat_fixed = 8;
    clear_obs();
    cycle(1, 5, 0, 0, 0);
    for (int i = 0; i < 50 && m_issued < 2; i++) cycle(0, 0, 0, 1, 0);
    check_val("mid_issued", issued, 2);
    pulse_reset();
    for (int i = 0; i < 30 && due_q.size() > 0; i++) cycle(0, 0, 0, 0, 0);
    cycle(0, 0, 0, 0, 0);
    check_val("post_rst_err", err_spurious, 1);

    // Latencies 4, 9, 2 with a restart attempt while busy.
    lat_mode = 1; lat_list = '{4, 9, 2};
    clear_obs();
    cycle(1, 3, 8, 0, 0);
    for (int i = 0; i < 200 && m_active; i++) cycle((i == 3), 7, 0, 1, 0);
    check_val("seq_last_lat", last_lat, 2);
    check_val("seq_max_lat", max_lat, 9);
    check_val("seq_issued", issued, 3);
    check_val("seq_run_done", run_done_cnt, 1);

    // Randomized runs.
    lat_mode = 2;
    for (int r = 0; r < 14; r++) begin
      run($urandom_range(0, 9), $urandom_range(0, 3), $urandom_range(30, 100));
      for (int k = 0; k < 3; k++) cycle(0, 0, 0, 0, ($urandom_range(0, 3) == 0));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
